// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_pkg : shared types/constants for the memory-port arbiter            |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    localparam int                 c_cnt_w   = 4;
    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    // Burst counter stops at all-ones so a long solo run can never look short again
    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v);
        return (v == c_cnt_max) ? v : v + c_cnt_one;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter_if : two requester ports plus the shared memory port       |
// | Revision            : 1.0                                                   |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_we;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_we;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_ena;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    logic              cpu_stall;

    // Requesters and the memory model together
    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_we, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wr_ena, mem_wr_data,
        output mem_rd_data,
        input  cpu_stall
    );

    // The arbiter
    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_we, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wr_ena, mem_wr_data,
        input  mem_rd_data,
        output cpu_stall
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_pick : pure winner / next-state / next-count logic for the arbiter      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  wire arb_state_t          i_st,
    input  wire logic [c_cnt_w-1:0]  i_cnt,
    input  wire logic                i_req0,
    input  wire logic                i_req1,
    output logic                     o_gnt_any,
    output logic                     o_win,
    output arb_state_t               o_st_nxt,
    output logic [c_cnt_w-1:0]       o_cnt_nxt
);

    localparam logic [c_cnt_w-1:0] c_burst = c_cnt_w'(BURST_MAX);

    logic       w_limit;
    arb_state_t w_own;

    assign w_limit = (i_cnt >= c_burst);

    always_comb begin
        o_gnt_any = i_req0 | i_req1;
        o_win     = REQ_CPU;
        o_st_nxt  = ARB_IDLE;
        o_cnt_nxt = '0;
        w_own     = ARB_OWN0;

        // Under contention the last owner keeps the port until its burst is used up
        if (i_req0 && i_req1) begin
            case (i_st)
                ARB_OWN0: o_win = w_limit ? REQ_AUX : REQ_CPU;
                ARB_OWN1: o_win = w_limit ? REQ_CPU : REQ_AUX;
                default:  o_win = REQ_CPU;
            endcase
        end else if (i_req1) begin
            o_win = REQ_AUX;
        end

        if (o_gnt_any) begin
            w_own     = (o_win == REQ_AUX) ? ARB_OWN1 : ARB_OWN0;
            o_st_nxt  = w_own;
            o_cnt_nxt = (i_st == w_own) ? sat_inc(i_cnt) : c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter : CPU / auxiliary master arbiter for the shared memory port|
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t          r_st;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_rd_pend;
    logic                r_rd_who;

    logic                w_pick_any;
    logic                w_win;
    arb_state_t          w_st_nxt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;

    logic                w_gnt_any;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_we;

    arb_pick #(
        .BURST_MAX (BURST_MAX)
    ) u_pick (
        .i_st      (r_st),
        .i_cnt     (r_cnt),
        .i_req0    (bus.m0_req),
        .i_req1    (bus.m1_req),
        .o_gnt_any (w_pick_any),
        .o_win     (w_win),
        .o_st_nxt  (w_st_nxt),
        .o_cnt_nxt (w_cnt_nxt)
    );

    // Reset blocks every grant combinationally, not just the registered state
    assign w_gnt_any = w_pick_any & ~rst;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        if (w_gnt_any) begin
            if (w_win == REQ_AUX) begin
                w_sel_addr  = bus.m1_addr;
                w_sel_wdata = bus.m1_wdata;
                w_sel_we    = bus.m1_we;
            end else begin
                w_sel_addr  = bus.m0_addr;
                w_sel_wdata = bus.m0_wdata;
                w_sel_we    = bus.m0_we;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st      <= ARB_IDLE;
            r_cnt     <= '0;
            r_rd_pend <= 1'b0;
            r_rd_who  <= REQ_CPU;
        end else begin
            r_st      <= w_st_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_pend <= w_gnt_any & ~w_sel_we;
            r_rd_who  <= w_win;
        end
    end

    assign bus.mem_addr    = w_sel_addr;
    assign bus.mem_wr_data = w_sel_wdata;
    assign bus.mem_wr_ena  = w_sel_we;

    assign bus.m0_gnt    = w_gnt_any & (w_win == REQ_CPU);
    assign bus.m1_gnt    = w_gnt_any & (w_win == REQ_AUX);
    assign bus.m0_rvalid = r_rd_pend & ~rst & (r_rd_who == REQ_CPU);
    assign bus.m1_rvalid = r_rd_pend & ~rst & (r_rd_who == REQ_AUX);
    assign bus.m0_rdata  = bus.mem_rd_data;
    assign bus.m1_rdata  = bus.mem_rd_data;
    assign bus.cpu_stall = bus.m0_req & ~bus.m0_gnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench, BURST_MAX 4 and 1       |
// | Revision            : 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side hold rule: fields must not move while req waits ungranted
    bit        mon_w [4];
    bit [64:0] mon_f [4];
    always @(negedge clk) begin
        logic [64:0] f [4];
        logic        r [4];
        logic        g [4];
        f[0] = {bus4.m0_we, bus4.m0_addr, bus4.m0_wdata}; r[0] = bus4.m0_req; g[0] = bus4.m0_gnt;
        f[1] = {bus4.m1_we, bus4.m1_addr, bus4.m1_wdata}; r[1] = bus4.m1_req; g[1] = bus4.m1_gnt;
        f[2] = {bus1.m0_we, bus1.m0_addr, bus1.m0_wdata}; r[2] = bus1.m0_req; g[2] = bus1.m0_gnt;
        f[3] = {bus1.m1_we, bus1.m1_addr, bus1.m1_wdata}; r[3] = bus1.m1_req; g[3] = bus1.m1_gnt;
        for (int k = 0; k < 4; k++) begin
            if (mon_w[k] && r[k] === 1'b1) begin
                n_checks++;
                if (f[k] !== mon_f[k]) begin
                    n_fail++;
                    $display("FAIL protocol_hold port %0d: fields %h, held %h", k, f[k], mon_f[k]);
                end
            end
            mon_w[k] = (r[k] === 1'b1) && (g[k] !== 1'b1) && !rst;
            mon_f[k] = f[k];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus4.m0_req = 0; bus4.m0_addr = '0; bus4.m0_we = 0; bus4.m0_wdata = '0;
        bus4.m1_req = 0; bus4.m1_addr = '0; bus4.m1_we = 0; bus4.m1_wdata = '0;
        bus1.m0_req = 0; bus1.m0_addr = '0; bus1.m0_we = 0; bus1.m0_wdata = '0;
        bus1.m1_req = 0; bus1.m1_addr = '0; bus1.m1_we = 0; bus1.m1_wdata = '0;
        bus4.mem_rd_data = 32'hDEAD_BEEF;
        bus1.mem_rd_data = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        bus4.m0_req = 1; bus4.m0_addr = 32'h44; bus4.m0_wdata = 32'h55;
        @(negedge clk);
        n_checks++; if (bus4.m0_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_m0_gnt: got %b want 0", bus4.m0_gnt); end
        n_checks++; if (bus4.m1_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_m1_gnt: got %b want 0", bus4.m1_gnt); end
        n_checks++; if (bus4.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", bus4.mem_addr); end
        n_checks++; if (bus4.mem_wr_ena !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ena: got %b want 0", bus4.mem_wr_ena); end
        n_checks++; if (bus4.m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m0_rvalid: got %b want 0", bus4.m0_rvalid); end
        n_checks++; if (bus4.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_stall: got %b want 1", bus4.cpu_stall); end
        n_checks++; if (bus1.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_stall_noreq: got %b want 0", bus1.cpu_stall); end
        tick();
        rst = 0;
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_single_read();
        tick();
        bus4.m0_req = 1; bus4.m0_addr = 32'h0000_0040; bus4.m0_we = 0;
        @(negedge clk);
        n_checks++; if (bus4.m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_m0_gnt: got %b want 1", bus4.m0_gnt); end
        n_checks++; if (bus4.m1_gnt !== 1'b0) begin n_fail++; $display("FAIL rd_m1_gnt: got %b want 0", bus4.m1_gnt); end
        n_checks++; if (bus4.mem_addr !== 32'h40) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 40", bus4.mem_addr); end
        n_checks++; if (bus4.mem_wr_ena !== 1'b0) begin n_fail++; $display("FAIL rd_wr_ena: got %b want 0", bus4.mem_wr_ena); end
        n_checks++; if (bus4.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rd_cpu_stall: got %b want 0", bus4.cpu_stall); end
        tick();
        bus4.m0_req = 0;
        @(negedge clk);
        n_checks++; if (bus4.m0_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_m0_rvalid: got %b want 1", bus4.m0_rvalid); end
        n_checks++; if (bus4.m0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_m0_rdata: got %h want deadbeef", bus4.m0_rdata); end
        n_checks++; if (bus4.m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_m1_rvalid: got %b want 0", bus4.m1_rvalid); end
        n_checks++; if (bus4.m1_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_m1_rdata: got %h want deadbeef", bus4.m1_rdata); end
    endtask

    task automatic test_contention_burst4();
        logic [9:0] exp_win;
        logic       e;
        logic       prev;
        exp_win = 10'b0011110000;
        prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus4.m0_req = 1; bus4.m0_addr = 32'h200; bus4.m0_we = 0;
            bus4.m1_req = 1; bus4.m1_addr = 32'h300; bus4.m1_we = 0;
            @(negedge clk);
            e = exp_win[i];
            n_checks++; if (bus4.m0_gnt !== ~e) begin n_fail++; $display("FAIL burst4_m0_gnt c%0d: got %b want %b", i, bus4.m0_gnt, ~e); end
            n_checks++; if (bus4.m1_gnt !== e) begin n_fail++; $display("FAIL burst4_m1_gnt c%0d: got %b want %b", i, bus4.m1_gnt, e); end
            n_checks++; if (bus4.cpu_stall !== e) begin n_fail++; $display("FAIL burst4_stall c%0d: got %b want %b", i, bus4.cpu_stall, e); end
            n_checks++; if (bus4.mem_addr !== (e ? 32'h300 : 32'h200)) begin n_fail++; $display("FAIL burst4_addr c%0d: got %h", i, bus4.mem_addr); end
            if (i > 0) begin
                n_checks++; if (bus4.m1_rvalid !== prev) begin n_fail++; $display("FAIL burst4_m1_rvalid c%0d: got %b want %b", i, bus4.m1_rvalid, prev); end
                n_checks++; if (bus4.m0_rvalid !== ~prev) begin n_fail++; $display("FAIL burst4_m0_rvalid c%0d: got %b want %b", i, bus4.m0_rvalid, ~prev); end
            end
            prev = e;
        end
        tick();
        idle_all();
        @(negedge clk);
        n_checks++; if (bus4.m0_rvalid !== 1'b1) begin n_fail++; $display("FAIL burst4_tail_rvalid: got %b want 1", bus4.m0_rvalid); end
        n_checks++; if (bus4.m0_gnt !== 1'b0) begin n_fail++; $display("FAIL burst4_idle_gnt: got %b want 0", bus4.m0_gnt); end
    endtask

    task automatic test_aux_write();
        tick();
        bus4.m1_req = 1; bus4.m1_addr = 32'h100; bus4.m1_we = 1; bus4.m1_wdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++; if (bus4.m1_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_m1_gnt: got %b want 1", bus4.m1_gnt); end
        n_checks++; if (bus4.m0_gnt !== 1'b0) begin n_fail++; $display("FAIL wr_m0_gnt: got %b want 0", bus4.m0_gnt); end
        n_checks++; if (bus4.mem_wr_ena !== 1'b1) begin n_fail++; $display("FAIL wr_ena: got %b want 1", bus4.mem_wr_ena); end
        n_checks++; if (bus4.mem_wr_data !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_data: got %h want 12345678", bus4.mem_wr_data); end
        n_checks++; if (bus4.mem_addr !== 32'h100) begin n_fail++; $display("FAIL wr_addr: got %h want 100", bus4.mem_addr); end
        tick();
        idle_all();
        @(negedge clk);
        n_checks++; if (bus4.m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_m1_rvalid: got %b want 0", bus4.m1_rvalid); end
        n_checks++; if (bus4.m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_m0_rvalid: got %b want 0", bus4.m0_rvalid); end
        n_checks++; if (bus4.mem_wr_ena !== 1'b0) begin n_fail++; $display("FAIL wr_idle_ena: got %b want 0", bus4.mem_wr_ena); end
    endtask

    task automatic test_alternate_burst1();
        logic [5:0] exp_win;
        exp_win = 6'b101010;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus1.m0_req = 1; bus1.m0_addr = 32'h10; bus1.m0_we = 0;
            bus1.m1_req = 1; bus1.m1_addr = 32'h20; bus1.m1_we = 0;
            @(negedge clk);
            n_checks++; if (bus1.m0_gnt !== ~exp_win[i]) begin n_fail++; $display("FAIL alt_m0_gnt c%0d: got %b want %b", i, bus1.m0_gnt, ~exp_win[i]); end
            n_checks++; if (bus1.m1_gnt !== exp_win[i]) begin n_fail++; $display("FAIL alt_m1_gnt c%0d: got %b want %b", i, bus1.m1_gnt, exp_win[i]); end
        end
        tick();
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_reset_kills_rvalid();
        for (int i = 0; i < 4; i++) begin
            tick();
            bus4.m0_req = 1; bus4.m0_addr = 32'h40; bus4.m0_we = 0;
            @(negedge clk);
            n_checks++; if (bus4.m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rk_m0_gnt c%0d: got %b want 1", i, bus4.m0_gnt); end
        end
        tick();
        rst = 1;
        bus4.m0_req = 0;
        @(negedge clk);
        n_checks++; if (bus4.m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rk_m0_rvalid: got %b want 0", bus4.m0_rvalid); end
        tick();
        rst = 0;
        bus4.m0_req = 1; bus4.m0_addr = 32'h80;
        bus4.m1_req = 1; bus4.m1_addr = 32'h90;
        @(negedge clk);
        n_checks++; if (bus4.m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rk_post_m0_gnt: got %b want 1", bus4.m0_gnt); end
        n_checks++; if (bus4.m1_gnt !== 1'b0) begin n_fail++; $display("FAIL rk_post_m1_gnt: got %b want 0", bus4.m1_gnt); end
        n_checks++; if (bus4.m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rk_post_rvalid: got %b want 0", bus4.m0_rvalid); end
        tick();
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_drop_and_saturate();
        for (int i = 0; i < 19; i++) begin
            tick();
            bus4.m0_req = 1; bus4.m0_addr = 32'h500; bus4.m0_we = 0;
            bus4.m1_addr = 32'h600; bus4.m1_we = 1; bus4.m1_wdata = 32'hAAAA_5555;
            bus4.m1_req = (i < 2 || i >= 17);
            @(negedge clk);
            if (i < 17) begin
                n_checks++; if (bus4.m0_gnt !== 1'b1) begin n_fail++; $display("FAIL sat_m0_gnt c%0d: got %b want 1", i, bus4.m0_gnt); end
                n_checks++; if (bus4.m1_gnt !== 1'b0) begin n_fail++; $display("FAIL sat_m1_gnt c%0d: got %b want 0", i, bus4.m1_gnt); end
                n_checks++; if (bus4.mem_addr !== 32'h500) begin n_fail++; $display("FAIL sat_addr c%0d: got %h want 500", i, bus4.mem_addr); end
                n_checks++; if (bus4.mem_wr_ena !== 1'b0) begin n_fail++; $display("FAIL sat_wr_ena c%0d: got %b want 0", i, bus4.mem_wr_ena); end
                n_checks++; if (bus4.m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL sat_m1_rvalid c%0d: got %b want 0", i, bus4.m1_rvalid); end
            end else begin
                n_checks++; if (bus4.m1_gnt !== 1'b1) begin n_fail++; $display("FAIL sat_late_m1_gnt c%0d: got %b want 1", i, bus4.m1_gnt); end
                n_checks++; if (bus4.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL sat_late_stall c%0d: got %b want 1", i, bus4.cpu_stall); end
                n_checks++; if (bus4.mem_wr_ena !== 1'b1) begin n_fail++; $display("FAIL sat_late_wr_ena c%0d: got %b want 1", i, bus4.mem_wr_ena); end
                n_checks++; if (bus4.mem_addr !== 32'h600) begin n_fail++; $display("FAIL sat_late_addr c%0d: got %h want 600", i, bus4.mem_addr); end
            end
        end
        tick();
        idle_all();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        idle_all();
        #2 rst = 1'b1;
        test_reset();
        test_single_read();
        test_contention_burst4();
        test_aux_write();
        test_alternate_burst1();
        test_reset_kills_rvalid();
        test_drop_and_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
